// File: rtl/mag_shift_multiplier.sv
// Signed-operand front end plus DW-step shift-add core: emits |A*B| with the raw operand sign bits.
// Optional MAG_MULT_EARLY_EXIT_EN ends the multiply once the remaining multiplier bits are all zero.
module mag_shift_multiplier #(
  parameter int unsigned DW   = 8,
  parameter int unsigned DW_2 = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   multiplier,
  input  logic [DW-1:0]   multiplicand,
  output logic            ready,
  output logic            done,
  output logic            multiplier_msb,
  output logic            multiplicand_msb,
  output logic [DW_2-1:0] product
);

  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MULT, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   a_q, b_q;
  logic [DW-1:0]   a_mag, b_mag;
  logic [DW-1:0]   mplier_sh;
  logic [DW_2-1:0] mcand_sh;
  logic [DW_2-1:0] acc, acc_nxt;
  logic [CW-1:0]   cnt;
  logic            last_step;
  logic            accept, load_en, step_en;

  // -2^(DW-1) negates to itself, which reads correctly as 2^(DW-1) unsigned
  assign a_mag   = multiplier_msb   ? DW'(~a_q + DW'(1)) : a_q;
  assign b_mag   = multiplicand_msb ? DW'(~b_q + DW'(1)) : b_q;
  assign acc_nxt = mplier_sh[0] ? DW_2'(acc + mcand_sh) : acc;

`ifdef MAG_MULT_EARLY_EXIT_EN
  assign last_step = (cnt == CW'(DW - 1)) || (mplier_sh[DW-1:1] == '0);
`else
  assign last_step = (cnt == CW'(DW - 1));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_MULT;
      S_MULT: if (last_step) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath control strobes
  always_comb begin
    accept  = 1'b0;
    load_en = 1'b0;
    step_en = 1'b0;
    case (state)
      S_IDLE: accept  = start;
      S_LOAD: load_en = 1'b1;
      S_MULT: step_en = 1'b1;
      default: ;
    endcase
  end

  // Datapath and registered outputs; product is captured as the last step completes
  always_ff @(posedge clk) begin
    if (rst) begin
      ready            <= 1'b1;
      done             <= 1'b0;
      product          <= '0;
      multiplier_msb   <= 1'b0;
      multiplicand_msb <= 1'b0;
      a_q              <= '0;
      b_q              <= '0;
      mplier_sh        <= '0;
      mcand_sh         <= '0;
      acc              <= '0;
      cnt              <= '0;
    end else begin
      ready <= (state_nxt == S_IDLE);
      done  <= (state_nxt == S_DONE);
      if (accept) begin
        a_q              <= multiplier;
        b_q              <= multiplicand;
        multiplier_msb   <= multiplier[DW-1];
        multiplicand_msb <= multiplicand[DW-1];
      end
      if (load_en) begin
        mplier_sh <= a_mag;
        mcand_sh  <= DW_2'(b_mag);
        acc       <= '0;
        cnt       <= '0;
      end
      if (step_en) begin
        acc       <= acc_nxt;
        mcand_sh  <= DW_2'(mcand_sh << 1);
        mplier_sh <= DW'(mplier_sh >> 1);
        cnt       <= CW'(cnt + CW'(1));
        if (last_step) product <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mag_shift_multiplier.sv
// Directed bench for mag_shift_multiplier: vector table plus abort/ignore/reset corner sequences.
module tb_mag_shift_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  multiplier, multiplicand;
  logic        ready, done, multiplier_msb, multiplicand_msb;
  logic [15:0] product;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic        ma;
    logic        mb;
  } vec_t;

  vec_t vecs[8];

  mag_shift_multiplier #(.DW(8), .DW_2(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .multiplier       (multiplier),
    .multiplicand     (multiplicand),
    .ready            (ready),
    .done             (done),
    .multiplier_msb   (multiplier_msb),
    .multiplicand_msb (multiplicand_msb),
    .product          (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle index (start cycle = 0) at which done is expected
  function automatic int exp_lat(input logic [7:0] a);
    logic [7:0] mag;
    int steps;
    mag   = a[7] ? 8'(-a) : a;
    steps = 1;
    for (int i = 0; i < 8; i++) if (mag[i]) steps = i + 1;
`ifdef MAG_MULT_EARLY_EXIT_EN
    return 2 + steps;
`else
    return (steps > 0) ? 10 : 10;
`endif
  endfunction

  task automatic run_vec(input vec_t v);
    int lat;
    lat = 0;
    @(negedge clk);
    chk("ready_idle", 32'(ready), 32'd1);
    multiplier   = v.a;
    multiplicand = v.b;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ready_busy", 32'(ready), 32'd0);
    for (int c = 1; c < 40; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    chk("latency", 32'(lat), 32'(exp_lat(v.a)));
    chk("product", 32'(product), 32'(v.p));
    chk("multiplier_msb", 32'(multiplier_msb), 32'(v.ma));
    chk("multiplicand_msb", 32'(multiplicand_msb), 32'(v.mb));
    @(negedge clk);
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("ready_after", 32'(ready), 32'd1);
  endtask

  initial begin
    int n_done;
    int done_cyc;

    vecs[0] = '{a: 8'd5,    b: 8'd3,    p: 16'd15,    ma: 1'b0, mb: 1'b0};
    vecs[1] = '{a: 8'hF9,   b: 8'd6,    p: 16'd42,    ma: 1'b1, mb: 1'b0};
    vecs[2] = '{a: 8'h80,   b: 8'h80,   p: 16'h4000,  ma: 1'b1, mb: 1'b1};
    vecs[3] = '{a: 8'd1,    b: 8'd100,  p: 16'd100,   ma: 1'b0, mb: 1'b0};
    vecs[4] = '{a: 8'd0,    b: 8'hFB,   p: 16'd0,     ma: 1'b0, mb: 1'b1};
    vecs[5] = '{a: 8'd127,  b: 8'h80,   p: 16'd16256, ma: 1'b0, mb: 1'b1};
    vecs[6] = '{a: 8'hFF,   b: 8'hFF,   p: 16'd1,     ma: 1'b1, mb: 1'b1};
    vecs[7] = '{a: 8'd12,   b: 8'hF5,   p: 16'd132,   ma: 1'b0, mb: 1'b1};

    rst          = 1'b1;
    start        = 1'b0;
    multiplier   = '0;
    multiplicand = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_ma", 32'(multiplier_msb), 32'd0);
    chk("rst_mb", 32'(multiplicand_msb), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Start pulsed mid-operation must be ignored
    @(negedge clk);
    multiplier = 8'd5; multiplicand = 8'd3; start = 1'b1;
    n_done = 0; done_cyc = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (done) begin n_done++; done_cyc = c; end
      if (c == 4) begin start = 1'b1; multiplier = 8'd2; multiplicand = 8'd2; end
      else start = 1'b0;
    end
    chk("ignore_done_count", 32'(n_done), 32'd1);
    chk("ignore_done_cycle", 32'(done_cyc), 32'(exp_lat(8'd5)));
    chk("ignore_product", 32'(product), 32'd15);

    // Reset during an operation discards it
    multiplier = 8'hF7; multiplicand = 8'hF7; start = 1'b1;
    n_done = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) n_done++;
      if (c == 1) chk("abort_busy_ma", 32'(multiplier_msb), 32'd1);
      if (c == 5) rst = 1'b1;
      if (c == 6) begin
        rst = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_product", 32'(product), 32'd0);
        chk("abort_ma", 32'(multiplier_msb), 32'd0);
        chk("abort_mb", 32'(multiplicand_msb), 32'd0);
      end
    end
    chk("abort_no_done", 32'(n_done), 32'd0);

    // rst and start together: rst wins, nothing accepted
    @(negedge clk);
    rst = 1'b1; start = 1'b1; multiplier = 8'h80; multiplicand = 8'h80;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rststart_ready", 32'(ready), 32'd1);
    chk("rststart_ma", 32'(multiplier_msb), 32'd0);
    chk("rststart_mb", 32'(multiplicand_msb), 32'd0);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("rststart_no_done", 32'(n_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
